// File: rtl/ram64_arbiter_pkg.sv
// Shared types and sizes for the RAM64 two-requester arbiter.
// Controller state encoding and default geometry of the attached RAM64.
package ram64_arbiter_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 6;
    localparam int RAM64_DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_SERVE = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/ram64_arbiter_if.sv
// One requester's request/response bundle.
// The requester drives through the master modport; the arbiter sees the slave side.
interface ram64_arbiter_if
    import ram64_arbiter_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int AWIDTH = ADDR_W
) ();

    logic              valid;
    logic              ready;
    logic              we;
    logic [AWIDTH-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/ram64_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant plus a last-grant pointer.
// The pointer moves only on an actual grant, so idle or blocked cycles keep fairness history.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    // 1 means requester 1 received the most recent grant; reset favours requester 0.
    logic       r_last;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        if (i_enable) begin
            if (&i_req) begin
                w_grant = r_last ? 2'b01 : 2'b10;
            end else begin
                w_grant = i_req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (|w_grant) begin
            r_last <= w_grant[1];
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/ram64_arbiter.sv
// Shares one RAM64 between two requesters with round-robin arbitration and a
// bulk-clear sequencer; responses arrive one cycle after each grant.
module ram64_arbiter
    import ram64_arbiter_pkg::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter int               AWIDTH    = ADDR_W,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    ram64_arbiter_if.slave    req0,
    ram64_arbiter_if.slave    req1,
    input  logic              i_clear_start,
    output logic              o_busy,
    output logic              o_ram_load,
    output logic [AWIDTH-1:0] o_ram_address,
    output logic [WIDTH-1:0]  o_ram_in,
    input  logic [WIDTH-1:0]  i_ram_out
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = {AWIDTH{1'b1}};

    state_t            r_state;
    state_t            w_state_next;
    logic [AWIDTH-1:0] r_count;
    logic [AWIDTH-1:0] w_count_next;

    logic              w_arb_enable;
    logic [1:0]        w_valid;
    logic [1:0]        w_we;
    logic [1:0]        w_grant;
    logic [AWIDTH-1:0] w_addr  [2];
    logic [WIDTH-1:0]  w_wdata [2];

    assign w_valid    = {req1.valid, req0.valid};
    assign w_we       = {req1.we, req0.we};
    assign w_addr[0]  = req0.addr;
    assign w_addr[1]  = req1.addr;
    assign w_wdata[0] = req0.wdata;
    assign w_wdata[1] = req1.wdata;

    // A clear request pre-empts any grant in the same cycle and leaves the pointer alone.
    assign w_arb_enable = (r_state == ST_SERVE) && !i_clear_start;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_enable (w_arb_enable),
        .i_req    (w_valid),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SERVE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            ST_SERVE: begin
                if (i_clear_start) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (r_count == LAST_ADDR) begin
                    w_state_next = ST_SERVE;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + AWIDTH'(1);
                end
            end
            default: begin
                w_state_next = ST_SERVE;
            end
        endcase
    end

    always_comb begin
        o_ram_load    = 1'b0;
        o_ram_address = '0;
        o_ram_in      = '0;
        if (r_state == ST_CLEAR) begin
            o_ram_load    = 1'b1;
            o_ram_address = r_count;
            o_ram_in      = CLEAR_VAL;
        end else if (w_grant[0]) begin
            o_ram_load    = w_we[0];
            o_ram_address = w_addr[0];
            o_ram_in      = w_wdata[0];
        end else if (w_grant[1]) begin
            o_ram_load    = w_we[1];
            o_ram_address = w_addr[1];
            o_ram_in      = w_wdata[1];
        end
    end

    // Read data is the RAM word seen at the grant edge; writes echo their own data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic             r_valid;
        logic [WIDTH-1:0] r_rdata;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_rdata <= '0;
            end else begin
                r_valid <= w_grant[gi];
                if (w_grant[gi]) begin
                    r_rdata <= w_we[gi] ? w_wdata[gi] : i_ram_out;
                end
            end
        end
    end

    assign req0.ready     = w_grant[0];
    assign req1.ready     = w_grant[1];
    assign req0.rsp_valid = g_rsp[0].r_valid;
    assign req1.rsp_valid = g_rsp[1].r_valid;
    assign req0.rsp_rdata = g_rsp[0].r_rdata;
    assign req1.rsp_rdata = g_rsp[1].r_rdata;
    assign o_busy         = (r_state == ST_CLEAR);

endmodule
